// File: rtl/rv32imf_apu_wb_buffer.sv
// ============================================================================
// Module      : rv32imf_apu_wb_buffer
// Description : Write-back buffer that queues non-stallable APU results behind
//               the shared register-file write port, with credit-based issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32imf_apu_wb_buffer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int FLAG_W   = 5,
    parameter int DEPTH    = 4,
    parameter int N_RD     = 3,
    parameter int PRIO_BUF = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        apu_issue_i,
    output logic                        apu_issue_ok_o,
    input  logic                        apu_valid_i,
    input  logic [ADDR_W-1:0]           apu_waddr_i,
    input  logic [DATA_W-1:0]           apu_result_i,
    input  logic [FLAG_W-1:0]           apu_flags_i,
    input  logic                        block_i,
    input  logic                        ex_we_i,
    input  logic [ADDR_W-1:0]           ex_waddr_i,
    input  logic [DATA_W-1:0]           ex_wdata_i,
    output logic                        ex_stall_o,
    output logic                        wb_we_o,
    output logic [ADDR_W-1:0]           wb_waddr_o,
    output logic [DATA_W-1:0]           wb_wdata_o,
    output logic                        fflags_we_o,
    output logic [FLAG_W-1:0]           fflags_o,
    input  logic [N_RD*ADDR_W-1:0]      read_addr_i,
    input  logic [N_RD-1:0]             read_valid_i,
    output logic [N_RD-1:0]             dep_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output logic                        overflow_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam int c_INF_W = c_CNT_W + 1;
    localparam int c_SUM_W = c_INF_W + 1;

    logic [ADDR_W-1:0]  r_waddr [DEPTH];
    logic [DATA_W-1:0]  r_data  [DEPTH];
    logic [FLAG_W-1:0]  r_flags [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [c_INF_W-1:0] r_inflight;
    logic               r_overflow;

    logic               w_buf_has;
    logic               w_full;
    logic               w_c_valid;
    logic [ADDR_W-1:0]  w_c_addr;
    logic [DATA_W-1:0]  w_c_data;
    logic [FLAG_W-1:0]  w_c_flags;
    logic               w_c_wins;
    logic               w_enq;
    logic               w_enq_ok;
    logic               w_deq;
    logic               w_inc;
    logic               w_dec;
    logic               w_err;
    logic [c_SUM_W-1:0] w_sum;

    assign w_buf_has = (r_count != '0);
    assign w_full    = (r_count == c_CNT_W'(DEPTH));

    // The FIFO head has priority over a new arrival so write order is preserved.
    assign w_c_valid = w_buf_has | apu_valid_i;
    assign w_c_addr  = w_buf_has ? r_waddr[r_head] : apu_waddr_i;
    assign w_c_data  = w_buf_has ? r_data[r_head]  : apu_result_i;
    assign w_c_flags = w_buf_has ? r_flags[r_head] : apu_flags_i;

    assign w_c_wins  = w_c_valid & ~block_i &
                       ((PRIO_BUF != 0) | ~ex_we_i | w_full);

    assign ex_stall_o  = ex_we_i & w_c_wins;
    assign wb_we_o     = w_c_wins | ex_we_i;
    assign wb_waddr_o  = w_c_wins ? w_c_addr : (ex_we_i ? ex_waddr_i : '0);
    assign wb_wdata_o  = w_c_wins ? w_c_data : (ex_we_i ? ex_wdata_i : '0);
    assign fflags_we_o = w_c_wins;
    assign fflags_o    = w_c_wins ? w_c_flags : '0;

    assign w_enq    = apu_valid_i & (w_buf_has | ~w_c_wins);
    assign w_deq    = w_buf_has & w_c_wins;
    assign w_enq_ok = w_enq & (~w_full | w_deq);

    assign w_sum          = c_SUM_W'(r_count) + c_SUM_W'(r_inflight);
    assign apu_issue_ok_o = (w_sum < c_SUM_W'(DEPTH));

    assign w_inc = apu_issue_i & (r_inflight != {c_INF_W{1'b1}});
    assign w_dec = apu_valid_i & (r_inflight != '0);
    assign w_err = (apu_issue_i & ~apu_issue_ok_o) |
                   (apu_valid_i & (r_inflight == '0)) |
                   (w_enq & ~w_enq_ok);

    assign count_o    = r_count;
    assign overflow_o = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_vld      <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Clear before set: when full, enqueue reuses the slot being dequeued.
            if (w_deq) begin
                r_head        <= r_head + c_PTR_W'(1);
                r_vld[r_head] <= 1'b0;
            end
            if (w_enq_ok) begin
                r_tail        <= r_tail + c_PTR_W'(1);
                r_vld[r_tail] <= 1'b1;
            end
            if (w_enq_ok && !w_deq) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_enq_ok && w_deq) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_inc && !w_dec) begin
                r_inflight <= r_inflight + c_INF_W'(1);
            end else if (!w_inc && w_dec) begin
                r_inflight <= r_inflight - c_INF_W'(1);
            end
            if (w_err) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_ok) begin
            r_waddr[r_tail] <= apu_waddr_i;
            r_data[r_tail]  <= apu_result_i;
            r_flags[r_tail] <= apu_flags_i;
        end
    end

    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_dep
            logic w_hit;
            always_comb begin
                w_hit = 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (r_vld[j] && (r_waddr[j] == read_addr_i[gi*ADDR_W +: ADDR_W])) begin
                        w_hit = 1'b1;
                    end
                end
            end
            assign dep_o[gi] = read_valid_i[gi] & w_hit;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rv32imf_apu_wb_buffer.sv
// ============================================================================
// Module      : tb_rv32imf_apu_wb_buffer
// Description : Scoreboard bench for rv32imf_apu_wb_buffer, one instance per
//               arbitration policy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32imf_apu_wb_buffer;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
        logic        fwe;
        logic [4:0]  f;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: PRIO_BUF=0
    logic        issue, valid, blk, ex_we;
    logic [5:0]  waddr, ex_waddr;
    logic [31:0] result, ex_wdata;
    logic [4:0]  flags;
    logic [17:0] raddr;
    logic [2:0]  rvalid;
    logic        ok, stall, we, fwe, ovf;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ff;
    logic [2:0]  dep, cnt;

    // Instance 1: PRIO_BUF=1
    logic        b_issue, b_valid, b_ex_we;
    logic [5:0]  b_waddr, b_ex_waddr;
    logic [31:0] b_result, b_ex_wdata;
    logic [4:0]  b_flags;
    logic        b_ok, b_stall, b_we, b_fwe, b_ovf;
    logic [5:0]  b_wa;
    logic [31:0] b_wd;
    logic [4:0]  b_ff;
    logic [2:0]  b_dep, b_cnt;

    rv32imf_apu_wb_buffer #(.PRIO_BUF(0)) dut0 (
        .clk(clk), .rst(rst),
        .apu_issue_i(issue), .apu_issue_ok_o(ok),
        .apu_valid_i(valid), .apu_waddr_i(waddr), .apu_result_i(result), .apu_flags_i(flags),
        .block_i(blk), .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .ex_stall_o(stall), .wb_we_o(we), .wb_waddr_o(wa), .wb_wdata_o(wd),
        .fflags_we_o(fwe), .fflags_o(ff),
        .read_addr_i(raddr), .read_valid_i(rvalid), .dep_o(dep),
        .count_o(cnt), .overflow_o(ovf)
    );

    rv32imf_apu_wb_buffer #(.PRIO_BUF(1)) dut1 (
        .clk(clk), .rst(rst),
        .apu_issue_i(b_issue), .apu_issue_ok_o(b_ok),
        .apu_valid_i(b_valid), .apu_waddr_i(b_waddr), .apu_result_i(b_result), .apu_flags_i(b_flags),
        .block_i(1'b0), .ex_we_i(b_ex_we), .ex_waddr_i(b_ex_waddr), .ex_wdata_i(b_ex_wdata),
        .ex_stall_o(b_stall), .wb_we_o(b_we), .wb_waddr_o(b_wa), .wb_wdata_o(b_wd),
        .fflags_we_o(b_fwe), .fflags_o(b_ff),
        .read_addr_i(18'd0), .read_valid_i(3'd0), .dep_o(b_dep),
        .count_o(b_cnt), .overflow_o(b_ovf)
    );

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;
    int  checks = 0;
    int  errors = 0;

    function automatic wr_t mk(logic [5:0] a, logic [31:0] d, logic fw, logic [4:0] f);
        wr_t w;
        w.a = a; w.d = d; w.fwe = fw; w.f = f;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write monitors: every register-file write must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && we) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected actual=%h/%h required=none", wa, wd);
            end else begin
                e0 = q0.pop_front();
                if (wr_t'({wa, wd, fwe, ff}) !== e0) begin
                    errors++;
                    $display("FAIL wr0 actual=%h required=%h", {wa, wd, fwe, ff}, e0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_we) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected actual=%h/%h required=none", b_wa, b_wd);
            end else begin
                e1 = q1.pop_front();
                if (wr_t'({b_wa, b_wd, b_fwe, b_ff}) !== e1) begin
                    errors++;
                    $display("FAIL wr1 actual=%h required=%h", {b_wa, b_wd, b_fwe, b_ff}, e1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        issue = 0; valid = 0; blk = 0; ex_we = 0; waddr = 0; ex_waddr = 0;
        result = 0; ex_wdata = 0; flags = 0; raddr = 0; rvalid = 3'b111;
        b_issue = 0; b_valid = 0; b_ex_we = 0; b_waddr = 0; b_ex_waddr = 0;
        b_result = 0; b_ex_wdata = 0; b_flags = 0;

        // Reset state
        @(negedge clk);
        chk("rst_count", cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ok", ok, 1);
        chk("rst_we", we, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dep", dep, 0);
        chk("rst_b_ok", b_ok, 1);
        step();
        rst = 1'b0; rvalid = 0;

        // Bypass
        issue = 1; b_issue = 1;
        step();
        issue = 0; b_issue = 0;
        valid = 1; waddr = 6'h21; result = 32'h3F800000; flags = 5'h01;
        q0.push_back(mk(6'h21, 32'h3F800000, 1'b1, 5'h01));
        @(negedge clk);
        chk("byp_we", we, 1);
        chk("byp_fwe", fwe, 1);
        chk("byp_count", cnt, 0);
        step();
        valid = 0;
        @(negedge clk);
        chk("byp_count_after", cnt, 0);
        chk("byp_ovf", ovf, 0);
        step();

        // APU priority over EX
        b_valid = 1; b_waddr = 6'h08; b_result = 32'h40000000; b_flags = 5'h04;
        b_ex_we = 1; b_ex_waddr = 6'h09; b_ex_wdata = 32'h1234;
        q1.push_back(mk(6'h08, 32'h40000000, 1'b1, 5'h04));
        @(negedge clk);
        chk("prio1_stall", b_stall, 1);
        step();
        b_valid = 0;
        q1.push_back(mk(6'h09, 32'h1234, 1'b0, 5'h00));
        @(negedge clk);
        chk("prio1_ex_stall", b_stall, 0);
        step();
        b_ex_we = 0;

        // EX priority: three results queue, then drain in order
        issue = 1;
        step(); step(); step();
        issue = 0;
        for (int k = 0; k < 3; k++) begin
            ex_we = 1; ex_waddr = 6'h0A + 6'(k); ex_wdata = 32'h100 + 32'(k);
            valid = 1; waddr = 6'h01 + 6'(k); result = 32'hA0 + 32'(k); flags = 5'(k);
            q0.push_back(mk(6'h0A + 6'(k), 32'h100 + 32'(k), 1'b0, 5'h00));
            @(negedge clk);
            chk("prio0_stall", stall, 0);
            chk("prio0_fill_count", cnt, 64'(k));
            step();
        end
        ex_we = 0; valid = 0;
        for (int k = 0; k < 3; k++) q0.push_back(mk(6'h01 + 6'(k), 32'hA0 + 32'(k), 1'b1, 5'(k)));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("prio0_drain_count", cnt, 64'(3 - k));
            step();
        end
        @(negedge clk);
        chk("prio0_empty", cnt, 0);
        step();

        // Dependency on a buffered destination
        issue = 1;
        step();
        issue = 0;
        valid = 1; blk = 1; waddr = 6'h05; result = 32'h55; flags = 5'h00;
        @(negedge clk);
        chk("dep_blocked_we", we, 0);
        step();
        valid = 0;
        raddr = {6'h07, 6'h05, 6'h09}; rvalid = 3'b111;
        @(negedge clk);
        chk("dep_hit", dep, 3'b010);
        chk("dep_count", cnt, 1);
        step();
        blk = 0;
        q0.push_back(mk(6'h05, 32'h55, 1'b1, 5'h00));
        @(negedge clk);
        chk("dep_hit_during_write", dep, 3'b010);
        step();
        @(negedge clk);
        chk("dep_clear", dep, 3'b000);
        chk("dep_count_clear", cnt, 0);
        step();
        rvalid = 0;

        // Result without an outstanding issue
        chk("proto_ovf_before", ovf, 0);
        valid = 1; waddr = 6'h0F; result = 32'hF; flags = 5'h02;
        q0.push_back(mk(6'h0F, 32'hF, 1'b1, 5'h02));
        step();
        valid = 0;
        @(negedge clk);
        chk("proto_ovf", ovf, 1);
        step();

        // Credits
        issue = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cred_ok_pre", ok, 1);
            step();
        end
        issue = 0;
        @(negedge clk);
        chk("cred_ok_exhausted", ok, 0);
        valid = 1; blk = 1; waddr = 6'h11; result = 32'h11; flags = 5'h00;
        step();
        valid = 0;
        @(negedge clk);
        chk("cred_ok_buffered", ok, 0);
        chk("cred_count", cnt, 1);
        step();
        blk = 0;
        q0.push_back(mk(6'h11, 32'h11, 1'b1, 5'h00));
        @(negedge clk);
        chk("cred_ok_draining", ok, 0);
        step();
        @(negedge clk);
        chk("cred_ok_freed", ok, 1);
        chk("cred_count_empty", cnt, 0);

        // Full FIFO: EX loses when count==DEPTH
        issue = 1;
        step();
        issue = 0;
        for (int k = 0; k < 4; k++) begin
            ex_we = 1; ex_waddr = 6'h18 + 6'(k); ex_wdata = 32'h200 + 32'(k);
            valid = 1; waddr = 6'h28 + 6'(k); result = 32'h300 + 32'(k); flags = 5'(k);
            q0.push_back(mk(6'h18 + 6'(k), 32'h200 + 32'(k), 1'b0, 5'h00));
            @(negedge clk);
            chk("full_fill_stall", stall, 0);
            step();
        end
        valid = 0; ex_waddr = 6'h1F; ex_wdata = 32'h2FF;
        q0.push_back(mk(6'h28, 32'h300, 1'b1, 5'h00));
        @(negedge clk);
        chk("full_count", cnt, 4);
        chk("full_stall", stall, 1);
        step();
        ex_we = 0;
        for (int k = 1; k < 4; k++) q0.push_back(mk(6'h28 + 6'(k), 32'h300 + 32'(k), 1'b1, 5'(k)));
        @(negedge clk);
        chk("full_drain_count", cnt, 3);
        step(); step(); step();
        @(negedge clk);
        chk("full_drained", cnt, 0);
        step();

        // Reset with two buffered entries
        issue = 1;
        step(); step();
        issue = 0;
        valid = 1; blk = 1; waddr = 6'h12; result = 32'h12;
        step();
        waddr = 6'h13; result = 32'h13;
        step();
        valid = 0;
        @(negedge clk);
        chk("prerst_count", cnt, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", cnt, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_ok", ok, 1);
        step();
        rst = 1'b0; blk = 0;
        repeat (4) step();
        @(negedge clk);
        chk("postrst_count", cnt, 0);
        chk("postrst_we", we, 0);
        chk("postrst_ovf", ovf, 0);
        chk("postrst_ok", ok, 1);

        chk("q0_drained", 64'(q0.size()), 0);
        chk("q1_drained", 64'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
